// File: rtl/ita_activation_ctrl.sv
// ita_activation_ctrl: tile sequencer for the activation unit with credit-based issue and an output FIFO
module ita_activation_ctrl #(
    parameter int N          = 16,
    parameter int WIDTH      = 8,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16,
    parameter int GELU_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [1:0]           cfg_act_i,
    input  logic [LEN_W-1:0]     cfg_len_i,
    input  logic                 cfg_mode_i,
    input  logic [7:0]           cfg_mult_i,
    input  logic [7:0]           cfg_shift_i,
    input  logic [7:0]           cfg_add_i,
    input  logic [GELU_W-1:0]    cfg_one_i,
    input  logic [GELU_W-1:0]    cfg_b_i,
    input  logic [GELU_W-1:0]    cfg_c_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [N*WIDTH-1:0]   in_data_i,
    output logic [N*WIDTH-1:0]   act_data_o,
    output logic                 act_calc_en_o,
    output logic                 act_calc_en_q_o,
    output logic [1:0]           act_sel_o,
    output logic                 act_mode_o,
    output logic [7:0]           act_mult_o,
    output logic [7:0]           act_shift_o,
    output logic [7:0]           act_add_o,
    output logic [GELU_W-1:0]    act_one_o,
    output logic [GELU_W-1:0]    act_b_o,
    output logic [GELU_W-1:0]    act_c_o,
    input  logic [N*WIDTH-1:0]   act_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [N*WIDTH-1:0]   out_data_o,
    output logic                 out_last_o,
    output logic                 done_o,
    output logic                 busy_o
);
    localparam int DW = N * WIDTH;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 2) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    if (FIFO_DEPTH < LATENCY + 1) begin : g_depth_check
        $error("FIFO_DEPTH must be at least LATENCY+1");
    end

    state_t              r_state;
    logic                r_cfg_ready;
    logic                r_done;
    logic [LEN_W-1:0]    r_remaining;
    logic [1:0]          r_sel;
    logic                r_mode;
    logic [7:0]          r_mult;
    logic [7:0]          r_shift;
    logic [7:0]          r_add;
    logic [GELU_W-1:0]   r_one;
    logic [GELU_W-1:0]   r_b;
    logic [GELU_W-1:0]   r_c;
    logic [DW-1:0]       r_act_data;
    logic                r_en;
    logic                r_en_last;
    logic                r_en_q;
    logic [LATENCY-1:0]  r_sr;
    logic [LATENCY-1:0]  r_lsr;
    logic [DW:0]         r_mem [FIFO_DEPTH];
    logic [PW-1:0]       r_wr;
    logic [PW-1:0]       r_rd;
    logic [CW-1:0]       r_count;

    logic                w_cfg_hs;
    logic                w_in_ready;
    logic                w_in_hs;
    logic                w_out_valid;
    logic                w_pop;
    logic                w_push;
    logic [CW-1:0]       w_inflight;
    logic [DW:0]         w_head;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Beats in flight include the issue stage so a beat reserves its FIFO slot from the cycle it is accepted.
    // A same-cycle pop returns its slot immediately, which lets the loop sustain one beat per cycle.
    assign w_inflight  = CW'($countones(r_sr)) + CW'(r_en);
    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid && out_ready_i;
    assign w_push      = r_sr[LATENCY-1];
    assign w_head      = r_mem[r_rd];
    assign w_in_ready  = (r_state == S_RUN) && (r_remaining != '0) &&
                         (r_count + w_inflight < CW'(FIFO_DEPTH) + CW'(w_pop));
    assign w_in_hs     = in_valid_i && w_in_ready;
    assign w_cfg_hs    = cfg_valid_i && r_cfg_ready;

    // Tile sequencing: accept config, count issued beats, wait for the last beat to leave, pulse done.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_cfg_ready <= 1'b0;
            r_done      <= 1'b0;
            r_remaining <= '0;
            r_sel       <= 2'd0;
            r_mode      <= 1'b0;
            r_mult      <= '0;
            r_shift     <= '0;
            r_add       <= '0;
            r_one       <= '0;
            r_b         <= '0;
            r_c         <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cfg_hs) begin
                        r_sel       <= cfg_act_i;
                        r_mode      <= cfg_mode_i;
                        r_mult      <= cfg_mult_i;
                        r_shift     <= cfg_shift_i;
                        r_add       <= cfg_add_i;
                        r_one       <= cfg_one_i;
                        r_b         <= cfg_b_i;
                        r_c         <= cfg_c_i;
                        r_remaining <= cfg_len_i;
                        r_cfg_ready <= 1'b0;
                        if (cfg_len_i == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end else begin
                        r_cfg_ready <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_in_hs) begin
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (r_remaining == LEN_W'(1)) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_pop && w_head[DW] && w_inflight == '0 && r_count == CW'(1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_cfg_ready <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Issue register and the in-flight shift registers that mirror the activation pipeline.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_act_data <= '0;
            r_en       <= 1'b0;
            r_en_last  <= 1'b0;
            r_en_q     <= 1'b0;
            r_sr       <= '0;
            r_lsr      <= '0;
        end else begin
            if (w_in_hs) r_act_data <= in_data_i;
            r_en      <= w_in_hs;
            r_en_last <= w_in_hs && (r_remaining == LEN_W'(1));
            r_en_q    <= r_en;
            r_sr      <= (r_sr << 1) | LATENCY'(r_en);
            r_lsr     <= (r_lsr << 1) | LATENCY'(r_en_last);
        end
    end

    // Output FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= f_inc(r_wr);
            if (w_pop) r_rd <= f_inc(r_rd);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // FIFO storage: pipeline result tagged with its last-beat flag.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr] <= {r_lsr[LATENCY-1], act_data_i};
    end

    // The credit rule must never let a result arrive at a full FIFO unless a pop frees a slot.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_push) assert (r_count != CW'(FIFO_DEPTH) || w_pop);
    end

    assign cfg_ready_o     = r_cfg_ready;
    assign in_ready_o      = w_in_ready;
    assign act_data_o      = r_act_data;
    assign act_calc_en_o   = r_en;
    assign act_calc_en_q_o = r_en_q;
    assign act_sel_o       = r_sel;
    assign act_mode_o      = r_mode;
    assign act_mult_o      = r_mult;
    assign act_shift_o     = r_shift;
    assign act_add_o       = r_add;
    assign act_one_o       = r_one;
    assign act_b_o         = r_b;
    assign act_c_o         = r_c;
    assign out_valid_o     = w_out_valid;
    assign out_data_o      = w_out_valid ? w_head[DW-1:0] : '0;
    assign out_last_o      = w_out_valid && w_head[DW];
    assign done_o          = r_done;
    assign busy_o          = (r_state != S_IDLE);
endmodule

// File: tb/tb_ita_activation_ctrl.sv
// tb_ita_activation_ctrl: directed bench for the activation controller with a two-stage inverting activation model
module tb_ita_activation_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_valid = 1'b0;
    logic         cfg_ready;
    logic [1:0]   cfg_act = '0;
    logic [15:0]  cfg_len = '0;
    logic         cfg_mode = 1'b0;
    logic [7:0]   cfg_mult = '0;
    logic [7:0]   cfg_shift = '0;
    logic [7:0]   cfg_add = '0;
    logic [15:0]  cfg_one = '0;
    logic [15:0]  cfg_b = '0;
    logic [15:0]  cfg_c = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [127:0] act_data_o;
    logic         act_en;
    logic         act_en_q;
    logic [1:0]   act_sel;
    logic         act_mode;
    logic [7:0]   act_mult;
    logic [7:0]   act_shift;
    logic [7:0]   act_add;
    logic [15:0]  act_one;
    logic [15:0]  act_b;
    logic [15:0]  act_c;
    logic [127:0] act_data_i;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         out_last;
    logic         done;
    logic         busy;

    logic [127:0] p0 = '0;
    logic [127:0] p1 = '0;
    logic [74:0]  act_vec;
    logic [74:0]  e_vec = '0;
    int           cyc = 0;
    int           errors = 0;
    int           checks = 0;
    int           idx;
    int           hs_cyc;
    int           done_cyc;
    int           hold_acc;
    bit           hold_rdy;
    bit           saw_rdy;
    bit           timeout;
    logic [127:0] got_q[$];
    logic         last_q[$];
    int           ocyc_q[$];
    int           acc_q[$];

    ita_activation_ctrl dut (
        .clk_i(clk), .rst_i(rst),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_act_i(cfg_act), .cfg_len_i(cfg_len),
        .cfg_mode_i(cfg_mode), .cfg_mult_i(cfg_mult), .cfg_shift_i(cfg_shift), .cfg_add_i(cfg_add),
        .cfg_one_i(cfg_one), .cfg_b_i(cfg_b), .cfg_c_i(cfg_c),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .act_data_o(act_data_o), .act_calc_en_o(act_en), .act_calc_en_q_o(act_en_q),
        .act_sel_o(act_sel), .act_mode_o(act_mode), .act_mult_o(act_mult), .act_shift_o(act_shift),
        .act_add_o(act_add), .act_one_o(act_one), .act_b_o(act_b), .act_c_o(act_c),
        .act_data_i(act_data_i),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .out_last_o(out_last),
        .done_o(done), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Activation unit stand-in: result is the inverted beat, two cycles after issue.
    always @(posedge clk) begin
        p0 <= ~act_data_o;
        p1 <= p0;
    end
    assign act_data_i = p1;

    assign act_vec = {act_sel, act_mode, act_mult, act_shift, act_add, act_one, act_b, act_c};

    function automatic logic [127:0] beat(input int k);
        logic [31:0] w;
        w = 32'(k) * 32'h9E3779B1 ^ 32'h0BADF00D;
        return {w, ~w, w + 32'd1, w ^ 32'hFFFF0000};
    endfunction

    function automatic logic [74:0] cfgvec(input logic [1:0] a, input logic [7:0] m);
        return {a, m[0], m, {4'h0, m[3:0]}, ~m, {m, 8'h01}, {8'h02, m}, {m, ~m}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [1:0] a, input logic [15:0] len, input logic [7:0] m);
        cfg_act   = a;
        cfg_len   = len;
        cfg_mode  = m[0];
        cfg_mult  = m;
        cfg_shift = {4'h0, m[3:0]};
        cfg_add   = ~m;
        cfg_one   = {m, 8'h01};
        cfg_b     = {8'h02, m};
        cfg_c     = {m, ~m};
    endtask

    task automatic do_cfg(input logic [1:0] a, input logic [15:0] len, input logic [7:0] m);
        int t = 0;
        @(negedge clk);
        cfg_valid = 1'b1;
        set_cfg(a, len, m);
        #1;
        while (!cfg_ready && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("cfg_accept", 128'(cfg_ready), 128'(1));
        hs_cyc = cyc;
        e_vec = cfgvec(a, m);
    endtask

    task automatic run(input int len, input int base, input int vpct, input int rpct,
                       input int hold, input bit spam, input int budget);
        int  t0 = -1;
        bit  first = 1'b1;
        bit  prev_en = 1'b0;
        idx = 0; saw_rdy = 0; timeout = 0; done_cyc = -1; hold_acc = -1; hold_rdy = 1'b1;
        got_q.delete(); last_q.delete(); ocyc_q.delete(); acc_q.delete();
        while (1) begin
            @(negedge clk);
            if (t0 < 0) t0 = cyc;
            cfg_valid = spam;
            if (spam) set_cfg(2'd0, 16'd0, 8'hC7);
            in_valid  = (idx < len) && ($urandom_range(0, 99) < vpct);
            in_data   = beat(base + idx);
            out_ready = (cyc - t0 >= hold) && ($urandom_range(0, 99) < rpct);
            #1;
            if (!first) chk("en_q_delay", 128'(act_en_q), 128'(prev_en));
            first = 1'b0;
            prev_en = act_en;
            chk("cfg_stable", 128'(act_vec), 128'(e_vec));
            if (spam) chk("cfg_blocked", 128'(cfg_ready), 128'(0));
            if (in_ready) saw_rdy = 1'b1;
            if (hold > 0 && cyc - t0 == hold - 1) begin
                hold_acc = idx;
                hold_rdy = in_ready;
            end
            if (in_valid && in_ready) begin
                acc_q.push_back(cyc);
                idx++;
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                last_q.push_back(out_last);
                ocyc_q.push_back(cyc);
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc - t0 >= budget) begin
                timeout = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic check_tile(input int len, input int base);
        chk("timeout", 128'(timeout), 128'(0));
        chk("beat_count", 128'(got_q.size()), 128'(len));
        for (int i = 0; i < got_q.size() && i < len; i++) begin
            chk($sformatf("data%0d", i), got_q[i], ~beat(base + i));
            chk($sformatf("last%0d", i), 128'(last_q[i]), 128'(i == len - 1));
        end
        if (len > 0 && got_q.size() == len) chk("done_after_last", 128'(done_cyc), 128'(ocyc_q[len - 1] + 1));
    endtask

    initial begin
        int stale;
        int t;
        // reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_cfg_ready", 128'(cfg_ready), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_act_en", 128'(act_en), 128'(0));
        chk("rst_act_cfg", 128'(act_vec), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_cfg_ready", 128'(cfg_ready), 128'(1));

        // zero-length tile
        do_cfg(2'd2, 16'd0, 8'h5A);
        run(0, 0, 100, 100, 0, 1'b0, 10);
        chk("zero_timeout", 128'(timeout), 128'(0));
        chk("zero_done_cyc", 128'(done_cyc), 128'(hs_cyc + 1));
        chk("zero_no_beats", 128'(got_q.size()), 128'(0));
        chk("zero_no_in_ready", 128'(saw_rdy), 128'(0));
        @(negedge clk);
        #1;
        chk("zero_done_pulse", 128'(done), 128'(0));
        chk("zero_idle", 128'(busy), 128'(0));

        // streaming GELU tile at full rate
        do_cfg(2'd2, 16'd6, 8'h11);
        run(6, 0, 100, 100, 0, 1'b0, 50);
        check_tile(6, 0);
        if (acc_q.size() == 6 && ocyc_q.size() == 6) begin
            chk("first_latency", 128'(ocyc_q[0]), 128'(acc_q[0] + 4));
            chk("accept_span", 128'(acc_q[5] - acc_q[0]), 128'(5));
            chk("output_span", 128'(ocyc_q[5] - ocyc_q[0]), 128'(5));
        end

        // config isolation: new config offered during the tile, taken in the first idle cycle
        do_cfg(2'd1, 16'd3, 8'h33);
        run(3, 100, 100, 100, 0, 1'b1, 50);
        check_tile(3, 100);
        @(negedge clk);
        #1;
        chk("iso_first_idle_ready", 128'(cfg_ready), 128'(1));
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        chk("iso_new_cfg", 128'(act_vec), 128'(cfgvec(2'd0, 8'hC7)));
        chk("iso_new_done", 128'(done), 128'(1));
        @(negedge clk);
        #1;
        chk("iso_done_pulse", 128'(done), 128'(0));

        // backpressure: downstream stalled for 12 cycles
        do_cfg(2'd0, 16'd10, 8'h44);
        e_vec = cfgvec(2'd0, 8'h44);
        run(10, 200, 100, 100, 12, 1'b0, 100);
        chk("bp_accepted", 128'(hold_acc), 128'(4));
        chk("bp_in_ready", 128'(hold_rdy), 128'(0));
        check_tile(10, 200);

        // reset in the middle of a RELU tile
        do_cfg(2'd1, 16'd8, 8'h55);
        idx = 0;
        t = 0;
        while (idx < 3 && t < 20) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            in_valid  = 1'b1;
            in_data   = beat(400 + idx);
            out_ready = 1'b1;
            #1;
            if (in_ready) idx++;
            t++;
        end
        chk("mid_accepts", 128'(idx), 128'(3));
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_out_valid", 128'(out_valid), 128'(0));
        chk("mid_busy", 128'(busy), 128'(0));
        chk("mid_act_sel", 128'(act_sel), 128'(0));
        chk("mid_cfg_ready", 128'(cfg_ready), 128'(0));
        rst = 1'b0;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            #1;
            if (out_valid || act_en || busy) stale++;
        end
        chk("mid_no_stale", 128'(stale), 128'(0));
        chk("mid_ready_again", 128'(cfg_ready), 128'(1));

        // random valid/ready
        do_cfg(2'd2, 16'd100, 8'h77);
        run(100, 300, 50, 50, 0, 1'b0, 3000);
        check_tile(100, 300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
